// File: rtl/avg_pool_controller.sv
// avg_pool_controller: 2x2 average pooling sequencer for a square image.
// Ports: clk, reset (async, active-low), start -> busy, done;
//   image read side img_rd_en/img_addr/img_data; pool write side
//   pool_we/pool_addr/pool_data (floor average of four signed taps).
module avg_pool_controller #(
  parameter int IMG_W  = 28,
  parameter int DATA_W = 8,
  parameter int OUT_W  = 16
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  start,
  output logic                                  busy,
  output logic                                  done,
  output logic                                  img_rd_en,
  output logic [$clog2(IMG_W*IMG_W)-1:0]        img_addr,
  input  logic signed [DATA_W-1:0]              img_data,
  output logic                                  pool_we,
  output logic [$clog2((IMG_W/2)*(IMG_W/2))-1:0] pool_addr,
  output logic signed [OUT_W-1:0]               pool_data
);

  localparam int H   = IMG_W / 2;
  localparam int AW  = $clog2(IMG_W * IMG_W);
  localparam int PW  = $clog2(H * H);
  localparam int CW  = (H > 1) ? $clog2(H) : 1;
  localparam int ACW = DATA_W + 2;

  typedef enum logic [2:0] {
    S_IDLE, S_READ, S_LAST, S_WRITE, S_DONE
  } state_t;

  state_t state, state_nx;

  logic [CW-1:0]         r, c, r_nx, c_nx;
  logic [1:0]            k;
  logic signed [ACW-1:0] acc, pix, sum, avg;
  logic                  last_col, last_win;

  assign pix = $signed({{2{img_data[DATA_W-1]}}, img_data});
  assign sum = acc + pix;
  // Arithmetic shift gives floor division by 4 for negative sums.
  assign avg = sum >>> 2;

  assign last_col = (c == CW'(H - 1));
  assign last_win = last_col && (r == CW'(H - 1));

  function automatic logic [AW-1:0] tap(
    input logic [CW-1:0] rr,
    input logic [CW-1:0] cc,
    input logic [1:0]    kk
  );
    int a;
    a = 2 * int'(rr) * IMG_W + 2 * int'(cc)
      + (kk[1] ? IMG_W : 0) + int'(kk[0]);
    return AW'(a);
  endfunction

  always_comb begin
    r_nx = r;
    c_nx = c + CW'(1);
    if (last_col) begin
      c_nx = '0;
      r_nx = r + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:  if (start) state_nx = S_READ;
      S_READ:  if (k == 2'd3) state_nx = S_LAST;
      S_LAST:  state_nx = S_WRITE;
      S_WRITE: state_nx = last_win ? S_DONE : S_READ;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    busy      = 1'b0;
    done      = 1'b0;
    img_rd_en = 1'b0;
    pool_we   = 1'b0;
    unique case (state)
      S_READ: begin
        busy      = 1'b1;
        img_rd_en = 1'b1;
      end
      S_LAST:  busy = 1'b1;
      S_WRITE: begin
        busy    = 1'b1;
        pool_we = 1'b1;
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  // Read data lags the tap address by one cycle, so tap k's data is
  // consumed while k+1 is being issued; LAST absorbs the final tap.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r         <= '0;
      c         <= '0;
      k         <= '0;
      acc       <= '0;
      img_addr  <= '0;
      pool_addr <= '0;
      pool_data <= '0;
    end else begin
      unique case (state)
        S_IDLE: if (start) begin
          r        <= '0;
          c        <= '0;
          k        <= '0;
          img_addr <= '0;
        end
        S_READ: begin
          k <= k + 2'd1;
          if (k != 2'd3) img_addr <= tap(r, c, k + 2'd1);
          if (k == 2'd1)      acc <= pix;
          else if (k != 2'd0) acc <= sum;
        end
        S_LAST: begin
          acc       <= sum;
          pool_addr <= PW'(int'(r) * H + int'(c));
          pool_data <= {{(OUT_W-ACW){avg[ACW-1]}}, avg};
        end
        S_WRITE: begin
          k <= '0;
          if (last_win) begin
            r <= '0;
            c <= '0;
          end else begin
            r        <= r_nx;
            c        <= c_nx;
            img_addr <= tap(r_nx, c_nx, 2'd0);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_avg_pool_controller.sv
// tb_avg_pool_controller: table vectors, random images and reset /
// held-start sequences checked against a floor-average reference model.
module tb_avg_pool_controller;

  localparam int W  = 28;
  localparam int H  = W / 2;
  localparam int NW = H * H;
  localparam int NP = W * W;
  localparam int LAT_DONE = 6 * NW + 1;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  logic busy, done, img_rd_en, pool_we;
  logic [9:0] img_addr;
  logic signed [7:0] img_data = '0;
  logic [7:0] pool_addr;
  logic signed [15:0] pool_data;

  avg_pool_controller #(
    .IMG_W(W), .DATA_W(8), .OUT_W(16)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .busy(busy), .done(done),
    .img_rd_en(img_rd_en), .img_addr(img_addr),
    .img_data(img_data),
    .pool_we(pool_we), .pool_addr(pool_addr),
    .pool_data(pool_data)
  );

  always #5 clk = ~clk;

  int ecnt = 0;
  always @(posedge clk) ecnt <= ecnt + 1;

  logic signed [7:0] mem [NP];
  always @(posedge clk)
    if (img_rd_en) img_data <= mem[img_addr];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm,
                     input longint act,
                     input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d",
               nm, act, exp);
    end
  endtask

  function automatic int px(int rr, int cc, int kk);
    return (2*rr + kk/2) * W + 2*cc + kk%2;
  endfunction

  function automatic int model(int n);
    int s;
    s = 0;
    for (int kk = 0; kk < 4; kk++)
      s += int'(mem[px(n / H, n % H, kk)]);
    return (s >= 0) ? s / 4 : -((-s + 3) / 4);
  endfunction

  int wr_addr[$], wr_data[$], wr_cyc[$];
  int rd_addr[$], rd_cyc[$];
  int done_cyc;
  int ref_e;

  task automatic start_run();
    @(negedge clk);
    start = 1'b1;
    ref_e = ecnt;
  endtask

  task automatic capture(input int rf, input bit hold);
    int cy, nlow;
    wr_addr = {}; wr_data = {}; wr_cyc = {};
    rd_addr = {}; rd_cyc = {};
    done_cyc = -1;
    nlow = 0;
    for (int i = 0; i < LAT_DONE + 100; i++) begin
      @(negedge clk);
      if (!hold) start = 1'b0;
      cy = ecnt - rf;
      if (img_rd_en) begin
        rd_addr.push_back(int'(img_addr));
        rd_cyc.push_back(cy);
      end
      if (pool_we) begin
        wr_addr.push_back(int'(pool_addr));
        wr_data.push_back(int'(pool_data));
        wr_cyc.push_back(cy);
      end
      if (done) begin
        done_cyc = cy;
        chk("busy_at_done", busy, 0);
        chk("pool_addr_hold", pool_addr, NW - 1);
        break;
      end
      if (!busy) nlow++;
    end
    chk("busy_low_in_run", nlow, 0);
  endtask

  task automatic verify(input bit do_rd);
    int nc;
    chk("wr_count", wr_addr.size(), NW);
    nc = (wr_addr.size() < NW) ? wr_addr.size() : NW;
    for (int n = 0; n < nc; n++) begin
      chk($sformatf("wr_addr[%0d]", n), wr_addr[n], n);
      chk($sformatf("wr_data[%0d]", n), wr_data[n], model(n));
      chk($sformatf("wr_cyc[%0d]", n), wr_cyc[n], 6*(n+1));
    end
    if (do_rd) begin
      chk("rd_count", rd_addr.size(), 4*NW);
      nc = (rd_addr.size() < 4*NW) ? rd_addr.size() : 4*NW;
      for (int j = 0; j < nc; j++) begin
        chk($sformatf("rd_addr[%0d]", j), rd_addr[j],
            px((j/4) / H, (j/4) % H, j % 4));
        chk($sformatf("rd_cyc[%0d]", j), rd_cyc[j],
            6*(j/4) + 1 + j%4);
      end
    end
    chk("done_cycle", done_cyc, LAT_DONE);
  endtask

  task automatic chk_idle_out(input string nm);
    chk(nm, {busy, done, img_rd_en, pool_we,
             img_addr, pool_addr, pool_data}, 0);
  endtask

  typedef struct {
    int fill;
    logic [3:0][7:0] w0;
    logic [3:0][7:0] w1;
    int e0;
    int e1;
    int er;
  } vec_t;

  function automatic logic [31:0] pk(int a, int b,
                                     int c, int d);
    return {d[7:0], c[7:0], b[7:0], a[7:0]};
  endfunction

  task automatic load(input vec_t v);
    for (int i = 0; i < NP; i++) mem[i] = 8'(v.fill);
    for (int kk = 0; kk < 4; kk++) begin
      mem[px(0, 0, kk)] = $signed(v.w0[kk]);
      mem[px(0, 1, kk)] = $signed(v.w1[kk]);
    end
  endtask

  vec_t tbl[5];

  initial begin
    int nbad_rest;
    tbl[0] = '{fill: 0, w0: pk(8, 0, 0, 0),
               w1: pk(0, 0, 0, 0), e0: 2, e1: 0, er: 0};
    tbl[1] = '{fill: 127, w0: pk(127, 127, 127, 127),
               w1: pk(127, 127, 127, 127),
               e0: 127, e1: 127, er: 127};
    tbl[2] = '{fill: -128, w0: pk(-128, -128, -128, -128),
               w1: pk(-128, -128, -128, -128),
               e0: -128, e1: -128, er: -128};
    tbl[3] = '{fill: 0, w0: pk(-1, 0, 0, 0),
               w1: pk(1, 1, 1, 0), e0: -1, e1: 0, er: 0};
    tbl[4] = '{fill: 0, w0: pk(-128, -128, -128, -127),
               w1: pk(127, 127, 127, 126),
               e0: -128, e1: 126, er: 0};

    for (int i = 0; i < NP; i++) mem[i] = '0;

    repeat (3) @(negedge clk);
    chk_idle_out("reset_outputs");
    reset = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk_idle_out("post_reset_hold");
    end

    for (int t = 0; t < 5; t++) begin
      load(tbl[t]);
      start_run();
      capture(ref_e, 1'b0);
      verify(1'b1);
      chk($sformatf("tbl%0d_pool0", t),
          wr_data.size() > 0 ? wr_data[0] : -9999, tbl[t].e0);
      chk($sformatf("tbl%0d_pool1", t),
          wr_data.size() > 1 ? wr_data[1] : -9999, tbl[t].e1);
      nbad_rest = 0;
      for (int n = 2; n < wr_data.size(); n++)
        if (wr_data[n] != tbl[t].er) nbad_rest++;
      chk($sformatf("tbl%0d_rest", t), nbad_rest, 0);
      if (t == 0) begin
        chk("trace_rd60", rd_addr.size() > 67 ? rd_addr[64] : -1, 60);
        chk("trace_rd61", rd_addr.size() > 67 ? rd_addr[65] : -1, 61);
        chk("trace_rd88", rd_addr.size() > 67 ? rd_addr[66] : -1, 88);
        chk("trace_rd89", rd_addr.size() > 67 ? rd_addr[67] : -1, 89);
        chk("trace_wr16", wr_addr.size() > 16 ? wr_addr[16] : -1, 16);
      end
    end

    for (int t = 0; t < 2; t++) begin
      for (int i = 0; i < NP; i++) mem[i] = 8'($urandom);
      start_run();
      capture(ref_e, 1'b0);
      verify(1'b1);
    end

    for (int i = 0; i < NP; i++) mem[i] = 8'($urandom);
    start_run();
    repeat (300) begin
      @(negedge clk);
      start = 1'b0;
    end
    reset = 1'b0;
    #1;
    chk_idle_out("async_reset_now");
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 4) reset = 1'b1;
      chk_idle_out($sformatf("reset_quiet[%0d]", i));
    end
    start_run();
    capture(ref_e, 1'b0);
    verify(1'b1);

    for (int i = 0; i < NP; i++) mem[i] = 8'($urandom);
    start_run();
    capture(ref_e, 1'b1);
    verify(1'b1);
    @(negedge clk);
    chk("held_idle_busy", busy, 0);
    chk("held_idle_rd", img_rd_en, 0);
    @(negedge clk);
    chk("held_restart_rd", img_rd_en, 1);
    chk("held_restart_addr", img_addr, 0);
    start = 1'b0;
    capture(ref_e + LAT_DONE + 1, 1'b0);
    verify(1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/avg_pool_controller.md
AVG_POOL_CONTROLLER -- requirements
Module: avg_pool_controller

Interface
REQ-001 SHALL provide parameter IMG_W, default 28: image width and height in pixels (square image, even value).
REQ-002 SHALL provide parameter DATA_W, default 8: signed pixel width.
REQ-003 SHALL provide parameter OUT_W, default 16: signed pool result width.
REQ-004 SHALL have clk  input  1  single clock, all state updates on the rising edge.
REQ-005 SHALL have reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have start  input  1  request to pool one full image, sampled only in IDLE.
REQ-007 SHALL have busy  output  1  high while windows are being processed.
REQ-008 SHALL have done  output  1  one-cycle pulse after the last pool write.
REQ-009 SHALL have img_rd_en  output  1  image buffer read strobe.
REQ-010 SHALL have img_addr  output  clog2(IMG_W*IMG_W)  image read address, row-major.
REQ-011 SHALL have img_data  input  DATA_W  signed read data, valid exactly 1 cycle after img_rd_en.
REQ-012 SHALL have pool_we  output  1  pool buffer write strobe.
REQ-013 SHALL have pool_addr  output  clog2((IMG_W/2)**2)  pool write address, row-major.
REQ-014 SHALL have pool_data  output  OUT_W  signed 2x2 average.

Function
REQ-015 SHALL implement states IDLE, READ, LAST, WRITE, DONE.
REQ-016 IDLE: start=1 at a clock edge -> READ with window (r,c)=(0,0), tap k=0; start=0 -> stay.
REQ-017 READ: tap counter k advances 0..3, one per cycle; img_rd_en=1 every READ cycle; k=3 -> LAST.
REQ-018 Tap addresses, base=2r*IMG_W+2c: k0=base, k1=base+1, k2=base+IMG_W, k3=base+IMG_W+1.
REQ-019 Accumulator: loaded (not added) with sign-extended img_data in the cycle after tap k0 is issued; taps k1..k3 added in the following three cycles; width at least DATA_W+2 bits, no overflow possible.
REQ-020 LAST: img_rd_en=0; captures tap k3 data; -> WRITE.
REQ-021 WRITE: pool_we=1 for exactly one cycle; pool_addr=r*(IMG_W/2)+c; pool_data=accumulator arithmetic-shifted right by 2 (floor), sign-extended to OUT_W.
REQ-022 After WRITE: c increments; at c=IMG_W/2-1, c wraps to 0 and r increments; next state READ; after window (IMG_W/2-1, IMG_W/2-1) next state DONE.
REQ-023 DONE: done=1, busy=0, for one cycle; -> IDLE.
REQ-024 busy=1 in READ, LAST and WRITE; 0 in IDLE and DONE.
REQ-025 Latency, start sampled at edge 0: first img_rd_en in cycle 1, first pool_we in cycle 6, 6 cycles per window, last pool_we in cycle 6*(IMG_W/2)**2 (1176 at default), done in the following cycle (1177).
REQ-026 start while busy or in DONE SHALL be ignored; no queuing.
REQ-027 img_addr, pool_addr, pool_data SHALL hold their last values when their strobes are low; only strobes are significant.
REQ-028 Exactly (IMG_W/2)**2 pool writes per start, each pool address written once, in ascending order.

Reset
REQ-029 reset=0 SHALL immediately force state IDLE, busy=0, done=0, img_rd_en=0, pool_we=0, img_addr=0, pool_addr=0, pool_data=0, counters and accumulator 0, regardless of clk.
REQ-030 reset asserted mid-image SHALL abort without any further pool_we; after release, a new start SHALL restart at window (0,0).
REQ-031 Outputs SHALL hold reset values after release until a start is accepted.

Verification
REQ-032 Image with pixel[0]=8, all others 0, start pulse -> pool[0]=2, pool[1..195]=0, done in cycle 1177.
REQ-033 All pixels 127 -> all 196 pool entries 127; all pixels -128 -> all entries -128 (0xFF80).
REQ-034 Window (0,0) = {-1,0,0,0}, others 0 -> pool[0]=-1 (floor), pool[1]=0; window (0,1) = {1,1,1,0} -> pool[1]=0.
REQ-035 Address trace: window (1,2) taps -> img_addr 60,61,88,89 and pool_addr 16; pool_we count = 196.
REQ-036 Reset pulsed in cycle 300 -> all outputs 0 at once, no pool_we afterwards; restart -> full correct image, done 1177 cycles after the new start.
REQ-037 start held high through an entire run -> one run only until DONE; start still high in IDLE -> a second run begins, with its first img_rd_en in the cycle after the IDLE edge.
